// File: rtl/wb_ram_arb2_pkg.sv
// Shared definitions for the two-master Wishbone RAM arbiter:
// grant state encoding and the default ack-timeout length.
package wb_ram_arb2_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GNT0 = ST_GNT0,
    GNT1 = ST_GNT1
  } state_e;

  localparam int TMO_CYC_DEF = 15;

endpackage

// File: rtl/wb_ram_arb2_tmo.sv
// Ack-timeout counter: counts unacknowledged strobe cycles and flags the
// cycle in which the count reaches TMO_CYC (minimum 2).
module wb_ram_arb2_tmo
  import wb_ram_arb2_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] r_cnt;

  // i_stb is the owner's strobe before the timeout gating, so no loop forms.
  assign o_expire = i_stb & ~i_ack & (r_cnt == CW'(TMO_CYC));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr | ~i_stb | i_ack | o_expire) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_ram_arb2.sv
// Two-master round-robin Wishbone arbiter with bus lock in front of an 8x2k RAM.
// Optional ack timeout is built in when WB_RAM_ARB2_TIMEOUT_EN is defined.
module wb_ram_arb2
  import wb_ram_arb2_pkg::*;
#(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [31:0]   m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic          s_ack_i
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_last;
  logic   w_last_nxt;
  logic   w_stb_raw;
  logic   w_unused;

  assign w_unused = ^{m0_adr_i[31:AW], m0_dat_i[31:DW], m0_sel_i[3:1],
                      m1_adr_i[31:AW], m1_dat_i[31:DW], m1_sel_i[3:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Owner keeps the RAM while its cyc stays high; on release hand straight
  // to a waiting peer so no idle cycle is inserted.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          w_state_nxt = GNT1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = m1_cyc_i ? GNT1 : IDLE;
        end else begin
          w_state_nxt = GNT0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = m0_cyc_i ? GNT0 : IDLE;
        end else begin
          w_state_nxt = GNT1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    w_stb_raw = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 1'b0;
    s_adr_o   = {AW{1'b0}};
    s_dat_o   = {DW{1'b0}};
    case (r_state)
      GNT0: begin
        s_cyc_o   = m0_cyc_i;
        w_stb_raw = m0_stb_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i[0];
        s_adr_o   = m0_adr_i[AW-1:0];
        s_dat_o   = m0_dat_i[DW-1:0];
      end
      GNT1: begin
        s_cyc_o   = m1_cyc_i;
        w_stb_raw = m1_stb_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i[0];
        s_adr_o   = m1_adr_i[AW-1:0];
        s_dat_o   = m1_dat_i[DW-1:0];
      end
      default: begin
        s_cyc_o   = 1'b0;
        w_stb_raw = 1'b0;
      end
    endcase
  end

  assign m0_ack_o = s_ack_i & (r_state == GNT0);
  assign m1_ack_o = s_ack_i & (r_state == GNT1);
  assign m0_dat_o = (r_state == GNT0) ? {{(32-DW){1'b0}}, s_dat_i} : 32'h0000_0000;
  assign m1_dat_o = (r_state == GNT1) ? {{(32-DW){1'b0}}, s_dat_i} : 32'h0000_0000;

`ifdef WB_RAM_ARB2_TIMEOUT_EN
  logic w_tmo;

  wb_ram_arb2_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_stb    (w_stb_raw),
    .i_ack    (s_ack_i),
    .i_clr    (w_state_nxt != r_state),
    .o_expire (w_tmo)
  );

  // The expiring strobe is withheld from the RAM so it cannot complete late.
  assign s_stb_o  = w_stb_raw & ~w_tmo;
  assign m0_err_o = w_tmo & (r_state == GNT0);
  assign m1_err_o = w_tmo & (r_state == GNT1);
`else
  assign s_stb_o  = w_stb_raw;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule
